// File: rtl/uart_word_rx_if.sv
// uart_word_rx_if: serial-side inputs and word-side outputs of uart_word_rx.
//   Baud_Set    baud select (0..7), sampled by the receiver at start detect
//   uart_rx     asynchronous serial line, idle high
//   data        last completed word
//   Rx_Done     one-cycle pulse when data is updated
//   frame_err   one-cycle pulse on a bad stop (or parity) bit
//   timeout_err one-cycle pulse when a partial word is dropped
//   uart_state  high while a byte is in flight or a word is partially assembled
// master: line/baud driver; slave: the receiver.
interface uart_word_rx_if #(
  parameter int DATA_WIDTH = 256
);
  logic [2:0]            Baud_Set;
  logic                  uart_rx;
  logic [DATA_WIDTH-1:0] data;
  logic                  Rx_Done;
  logic                  frame_err;
  logic                  timeout_err;
  logic                  uart_state;
  modport master (output Baud_Set, uart_rx, input data, Rx_Done, frame_err, timeout_err, uart_state);
  modport slave  (input Baud_Set, uart_rx, output data, Rx_Done, frame_err, timeout_err, uart_state);
endinterface

// File: rtl/uart_word_rx.sv
// uart_word_rx: multi-byte UART receiver assembling DATA_WIDTH/8 characters into one word.
//   Clk   system clock
//   Rst_n asynchronous active-low reset
//   bus   uart_word_rx_if.slave (Baud_Set, uart_rx in; data, Rx_Done, frame_err,
//         timeout_err, uart_state out)
// Optional feature: define UART_PARITY_EN for 8E1 framing with even-parity checking.
module uart_word_rx #(
  parameter int DATA_WIDTH   = 256,
  parameter int MSB_FIRST    = 0,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic          Clk,
  input  logic          Rst_n,
  uart_word_rx_if.slave bus
);
  localparam int N  = DATA_WIDTH / 8;
  localparam int BW = N > 1 ? $clog2(N) : 1;
  localparam int PW = $clog2(DATA_WIDTH);
  localparam logic [12:0] DIVS [8] = '{13'd5208, 13'd2604, 13'd1302, 13'd868,
                                       13'd434, 13'd217, 13'd108, 13'd54};
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t                r_state, w_next;
  logic [1:0]            r_sync;
  logic                  r_rx_d;
  logic [12:0]           r_div, r_cnt;
  logic [2:0]            r_bit;
  logic [7:0]            r_shift;
  logic [BW-1:0]         r_bcnt;
  logic [20:0]           r_idle;
  logic [DATA_WIDTH-1:0] r_word, r_data, w_word;
  logic                  r_done, r_ferr, r_terr;
  logic                  w_rx, w_fall, w_tick, w_stop, w_bad, w_last, w_tout;
  logic [PW-1:0]         w_pos;
  logic [20:0]           w_tlim;
  assign w_rx   = r_sync[1];
  assign w_fall = r_rx_d & ~w_rx;
  // START waits half a bit to land in mid-bit; later phases wait a full bit.
  assign w_tick = r_cnt == (r_state == START ? {1'b0, r_div[12:1]} : r_div) - 13'd1;
  assign w_tlim = 21'(TIMEOUT_BITS) * {8'd0, r_div};
  assign w_tout = r_state == IDLE && r_bcnt != '0 && r_idle == w_tlim - 21'd1;
  assign w_last = r_bcnt == BW'(N - 1);
  assign w_pos  = MSB_FIRST != 0 ? PW'(DATA_WIDTH - 8) - PW'({r_bcnt, 3'b000}) : PW'({r_bcnt, 3'b000});
`ifdef UART_PARITY_EN
  logic r_perr;
  assign w_bad = w_stop & (~w_rx | r_perr);
`else
  assign w_bad = w_stop & ~w_rx;
`endif
  always_comb begin
    w_word = r_word;
    w_word[w_pos +: 8] = r_shift;
  end
  always_comb begin
    w_next = r_state;
    w_stop = 1'b0;
    case (r_state)
      IDLE:   w_next = w_fall ? START : IDLE;
      START:  w_next = w_tick ? (w_rx ? IDLE : DATA) : START;
`ifdef UART_PARITY_EN
      DATA:   w_next = w_tick && r_bit == 3'd7 ? PARITY : DATA;
      PARITY: w_next = w_tick ? STOP : PARITY;
`else
      DATA:   w_next = w_tick && r_bit == 3'd7 ? STOP : DATA;
`endif
      STOP: begin
        w_next = w_tick ? IDLE : STOP;
        w_stop = w_tick;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      r_sync  <= 2'b11;
      r_rx_d  <= 1'b1;
      r_div   <= '0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_bcnt  <= '0;
      r_idle  <= '0;
      r_word  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_terr  <= 1'b0;
`ifdef UART_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_sync <= {r_sync[0], bus.uart_rx};
      r_rx_d <= w_rx;
      r_done <= w_stop & ~w_bad & w_last;
      r_ferr <= w_bad;
      r_terr <= w_tout;
      r_cnt  <= (r_state == IDLE || w_tick) ? '0 : r_cnt + 13'd1;
      if (r_state == IDLE && w_fall) r_div <= DIVS[bus.Baud_Set];
      // r_bit wraps back to 0 after the eighth data bit.
      if (r_state == DATA && w_tick) begin
        r_shift <= {w_rx, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
`ifdef UART_PARITY_EN
      if (r_state == PARITY && w_tick) r_perr <= ^{r_shift, w_rx};
`endif
      r_idle <= (r_state == IDLE && r_bcnt != '0 && !w_fall && !w_tout) ? r_idle + 21'd1 : '0;
      // A timeout coinciding with a start edge clears the count, so that byte becomes byte 0.
      if (w_tout || w_bad) r_bcnt <= '0;
      else if (w_stop) begin
        r_word <= w_word;
        r_bcnt <= w_last ? '0 : r_bcnt + 1'b1;
        if (w_last) r_data <= w_word;
      end
    end
  assign bus.data        = r_data;
  assign bus.Rx_Done     = r_done;
  assign bus.frame_err   = r_ferr;
  assign bus.timeout_err = r_terr;
  assign bus.uart_state  = r_state != IDLE || r_bcnt != '0;
endmodule
